// File: rtl/snake_pkg.sv
// Shared game-timing definitions: state encoding, clock rate, display width and
// the wrapping seconds increment used by the elapsed-time counter.
package snake_pkg;

  localparam int CLK_FREQ_HZ = 25000000;
  localparam int TIME_W      = 10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_STOPPED = 2'd3;

  typedef struct packed {
    logic              wrap;
    logic [TIME_W-1:0] value;
  } sec_step_t;

  // Wraps to zero past the last displayable count, matching the digit counter.
  function automatic sec_step_t seconds_step(input logic [TIME_W-1:0] cur,
                                             input logic [TIME_W-1:0] max_sec);
    sec_step_t r;
    if (cur == max_sec) begin
      r.wrap  = 1'b1;
      r.value = {TIME_W{1'b0}};
    end else begin
      r.wrap  = 1'b0;
      r.value = cur + TIME_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/time_tik_generator_if.sv
// Game-control strobes into the tick generator and its timing outputs back to game logic.
interface time_tik_generator_if;
  import snake_pkg::*;

  logic              sync_reset;
  logic              game_start;
  logic              pause_toggle;
  logic              game_over;
  logic              time_tik;
  logic              running;
  logic [TIME_W-1:0] seconds;
  logic              time_wrap;

  modport master (
    output sync_reset, game_start, pause_toggle, game_over,
    input  time_tik, running, seconds, time_wrap
  );

  modport slave (
    input  sync_reset, game_start, pause_toggle, game_over,
    output time_tik, running, seconds, time_wrap
  );

endinterface

// File: rtl/time_tik_generator_pulse_stretcher.sv
// Loadable down-counter turning a one-cycle strobe into a HIGH_CYCLES-wide registered level.
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int CNT_W       = $clog2(HIGH_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic load_i,
  output logic level_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;

  // Next count: clear wins, a load restarts the window, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (load_i) begin
      cnt_d = CNT_W'(HIGH_CYCLES);
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Level flop tracks "count nonzero" without an extra cycle of latency.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= {CNT_W{1'b0}};
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= (cnt_d != {CNT_W{1'b0}});
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/time_tik_generator.sv
// Game-second tick source: state machine gating a prescaler, a wrapping seconds
// count, and a stretched time_tik level for the display digit counter.
module time_tik_generator
  import snake_pkg::*;
#(
  parameter int TICKS_PER_SEC   = CLK_FREQ_HZ,
  parameter int TIK_HIGH_CYCLES = 4,
  parameter int PRESC_BITS      = 25,
  parameter int MAX_SECONDS     = 999
) (
  input logic                 clock_25,
  input logic                 reset,
  time_tik_generator_if.slave bus
);

  localparam logic [PRESC_BITS-1:0] PRESC_LAST = PRESC_BITS'(TICKS_PER_SEC - 1);
  localparam logic [TIME_W-1:0]     SEC_MAX    = TIME_W'(MAX_SECONDS);

  logic [1:0]            state_q, state_d;
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  logic [TIME_W-1:0]     seconds_q, seconds_d;
  logic                  wrap_q, wrap_d;
  logic                  running_q;
  logic                  terminal_s;
  logic                  tik_s;
  sec_step_t             sec_step_s;

  // Next state; game_over outranks pause_toggle, STOPPED only leaves through a reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.game_start) state_d = ST_RUNNING;
        else                state_d = state_q;
      end
      ST_RUNNING: begin
        if (bus.game_over)         state_d = ST_STOPPED;
        else if (bus.pause_toggle) state_d = ST_PAUSED;
        else                       state_d = state_q;
      end
      ST_PAUSED: begin
        if (bus.game_over)         state_d = ST_STOPPED;
        else if (bus.pause_toggle) state_d = ST_RUNNING;
        else                       state_d = state_q;
      end
      ST_STOPPED: state_d = state_q;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Terminal count uses the current state, so a count finishing alongside a
  // pause or game_over still issues its tick before the prescaler freezes.
  assign terminal_s = (state_q == ST_RUNNING) && (presc_q == PRESC_LAST);
  assign sec_step_s = seconds_step(seconds_q, SEC_MAX);

  // Prescaler and seconds next-state.
  always_comb begin
    presc_d   = presc_q;
    seconds_d = seconds_q;
    wrap_d    = 1'b0;
    if (state_q == ST_RUNNING) begin
      if (terminal_s) presc_d = {PRESC_BITS{1'b0}};
      else            presc_d = presc_q + PRESC_BITS'(1);
    end else if ((state_q == ST_IDLE) && bus.game_start) begin
      presc_d = {PRESC_BITS{1'b0}};
    end else begin
      presc_d = presc_q;
    end
    if (terminal_s) begin
      seconds_d = sec_step_s.value;
      wrap_d    = sec_step_s.wrap;
    end else begin
      seconds_d = seconds_q;
      wrap_d    = 1'b0;
    end
  end

  // State, prescaler and output registers with sync_reset acting as a new-game clear.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= {PRESC_BITS{1'b0}};
      seconds_q <= {TIME_W{1'b0}};
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else if (bus.sync_reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= {PRESC_BITS{1'b0}};
      seconds_q <= {TIME_W{1'b0}};
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      seconds_q <= seconds_d;
      wrap_q    <= wrap_d;
      running_q <= (state_d == ST_RUNNING);
    end
  end

  pulse_stretcher #(
    .HIGH_CYCLES (TIK_HIGH_CYCLES)
  ) u_tik_stretch (
    .clk_i   (clock_25),
    .rst_n_i (reset),
    .clr_i   (bus.sync_reset),
    .load_i  (terminal_s),
    .level_o (tik_s)
  );

  assign bus.time_tik  = tik_s;
  assign bus.running   = running_q;
  assign bus.seconds   = seconds_q;
  assign bus.time_wrap = wrap_q;

endmodule

// File: tb/tb_time_tik_generator.sv
// Self-checking bench for time_tik_generator: directed scenarios plus random control
// pulses, all compared against a cycle-counting behavioural model.
module tb_time_tik_generator;

  localparam int TPS  = 10;
  localparam int HIGH = 4;
  localparam int MAXS = 3;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUS = 2;
  localparam int M_STOP = 3;

  logic clock_25 = 1'b0;
  logic reset    = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: game phase, running-cycle position within the current second,
  // remaining tick-high cycles, and elapsed seconds.
  int m_state, m_phase, m_tik_left, m_sec;
  bit m_wrap, m_run;

  time_tik_generator_if bus ();

  time_tik_generator #(
    .TICKS_PER_SEC   (TPS),
    .TIK_HIGH_CYCLES (HIGH),
    .PRESC_BITS      (4),
    .MAX_SECONDS     (MAXS)
  ) dut (
    .clock_25 (clock_25),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clock_25 = ~clock_25;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] obs_vec();
    return {bus.time_tik, bus.running, bus.seconds, bus.time_wrap};
  endfunction

  function automatic logic [12:0] exp_vec();
    return {(m_tik_left != 0), m_run, 10'(m_sec), m_wrap};
  endfunction

  task automatic model_clear();
    m_state = M_IDLE; m_phase = 0; m_tik_left = 0; m_sec = 0; m_wrap = 0; m_run = 0;
  endtask

  task automatic model_step(input bit s, input bit st, input bit p, input bit o);
    bit fire;
    if (s) begin
      model_clear();
      return;
    end
    fire = (m_state == M_RUN) && (m_phase == TPS - 1);
    if (m_state == M_RUN) m_phase = (m_phase + 1) % TPS;
    m_tik_left = fire ? HIGH : ((m_tik_left > 0) ? m_tik_left - 1 : 0);
    m_wrap = 0;
    if (fire) begin
      if (m_sec == MAXS) begin m_sec = 0; m_wrap = 1; end
      else m_sec = m_sec + 1;
    end
    case (m_state)
      M_IDLE: if (st) begin m_state = M_RUN; m_phase = 0; end
      M_RUN:  if (o) m_state = M_STOP; else if (p) m_state = M_PAUS;
      M_PAUS: if (o) m_state = M_STOP; else if (p) m_state = M_RUN;
      default: ;
    endcase
    m_run = (m_state == M_RUN);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input bit s, input bit st, input bit p, input bit o);
    bus.sync_reset = s; bus.game_start = st; bus.pause_toggle = p; bus.game_over = o;
    @(posedge clock_25);
    model_step(s, st, p, o);
    cyc++;
    @(negedge clock_25);
    bus.sync_reset = 1'b0; bus.game_start = 1'b0; bus.pause_toggle = 1'b0; bus.game_over = 1'b0;
  endtask

  task automatic test_reset();
    bus.sync_reset = 1'b0; bus.game_start = 1'b0; bus.pause_toggle = 1'b0; bus.game_over = 1'b0;
    model_clear();
    #3;
    n_tests++;
    if (obs_vec() !== 13'd0) begin
      n_fail++; $display("FAIL reset_hold: got %h want %h", obs_vec(), 13'd0);
    end
    @(negedge clock_25);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      drive(0, 0, 0, 0);
      n_tests++;
      if (obs_vec() !== 13'd0) begin
        n_fail++; $display("FAIL idle_quiet cyc %0d: got %h want %h", i, obs_vec(), 13'd0);
      end
    end
  endtask

  task automatic test_count();
    int rises[$];
    int widths[$];
    int hl;
    logic prev;
    logic [9:0] exp_sec;
    hl = 0; prev = 1'b0;
    cyc = 0;
    drive(0, 1, 0, 0);
    n_tests++;
    if (bus.running !== 1'b1) begin
      n_fail++; $display("FAIL running_after_start: got %b want 1", bus.running);
    end
    for (int k = 0; k < 45; k++) begin
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL count_model cyc %0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
      exp_sec = 10'(((cyc - 1) / TPS) % (MAXS + 1));
      n_tests++;
      if (bus.seconds !== exp_sec) begin
        n_fail++; $display("FAIL count_seconds cyc %0d: got %0d want %0d", cyc, bus.seconds, exp_sec);
      end
      n_tests++;
      if (bus.time_wrap !== (cyc == 41)) begin
        n_fail++; $display("FAIL wrap_timing cyc %0d: got %b want %b", cyc, bus.time_wrap, (cyc == 41));
      end
      if (bus.time_tik && !prev) rises.push_back(cyc);
      if (bus.time_tik) hl++;
      if (!bus.time_tik && prev) begin widths.push_back(hl); hl = 0; end
      prev = bus.time_tik;
      drive(0, 0, 0, 0);
    end
    n_tests++;
    if (rises.size() != 4) begin
      n_fail++; $display("FAIL rise_count: got %0d want 4", rises.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (rises[i] != 11 + TPS * i) begin
          n_fail++; $display("FAIL rise_cycle %0d: got %0d want %0d", i, rises[i], 11 + TPS * i);
        end
      end
    end
    for (int i = 0; i < widths.size(); i++) begin
      n_tests++;
      if (widths[i] != HIGH) begin
        n_fail++; $display("FAIL tik_width %0d: got %0d want %0d", i, widths[i], HIGH);
      end
    end
  endtask

  task automatic test_pause();
    int pcyc, rise_at, guard;
    logic [9:0] sec_hold;
    guard = 0;
    while (m_phase != 5 && guard < 2 * TPS) begin drive(0, 0, 0, 0); guard++; end
    pcyc = cyc;
    sec_hold = bus.seconds;
    drive(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      n_tests++;
      if (obs_vec() !== exp_vec() || bus.time_tik !== 1'b0 || bus.running !== 1'b0 ||
          bus.seconds !== sec_hold) begin
        n_fail++; $display("FAIL paused_hold cyc %0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
      if (i < 19) drive(0, 0, 0, 0);
      else        drive(0, 0, 1, 0);
    end
    rise_at = -1;
    for (int i = 0; i < 2 * TPS && rise_at < 0; i++) begin
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL resume_model cyc %0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
      if (bus.time_tik) rise_at = cyc;
      else drive(0, 0, 0, 0);
    end
    // Presc 5 at pause; remaining 5 counts plus 20 paused cycles.
    n_tests++;
    if (rise_at != pcyc + (TPS - 5) + 20) begin
      n_fail++; $display("FAIL resume_rise: got %0d want %0d", rise_at, pcyc + (TPS - 5) + 20);
    end
  endtask

  task automatic test_stop();
    int hi, rises, guard;
    logic prev;
    guard = 0;
    while (!bus.time_tik && guard < 2 * TPS) begin drive(0, 0, 0, 0); guard++; end
    n_tests++;
    if (!bus.time_tik) begin
      n_fail++; $display("FAIL stop_find_tik: got 0 want 1");
    end
    hi = 1; rises = 0; prev = 1'b1;
    drive(0, 0, 0, 0);
    if (bus.time_tik) hi++;
    drive(0, 0, 0, 1);
    for (int k = 0; k < 100; k++) begin
      n_tests++;
      if (obs_vec() !== exp_vec() || bus.running !== 1'b0) begin
        n_fail++; $display("FAIL stopped_model cyc %0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
      if (bus.time_tik) hi++;
      if (bus.time_tik && !prev) rises++;
      prev = bus.time_tik;
      drive(0, (k == 60), (k == 30), 0);
    end
    n_tests++;
    if (hi != HIGH || rises != 0) begin
      n_fail++; $display("FAIL stop_window: got high %0d rises %0d want high %0d rises 0", hi, rises, HIGH);
    end
  endtask

  task automatic test_simultaneous();
    int guard;
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    guard = 0;
    while (m_phase != TPS - 1 && guard < 2 * TPS) begin drive(0, 0, 0, 0); guard++; end
    drive(0, 0, 1, 0);
    n_tests++;
    if (bus.time_tik !== 1'b1 || bus.running !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL terminal_with_pause: got %h want %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    guard = 0;
    while (m_phase != TPS - 1 && guard < 2 * TPS) begin drive(0, 0, 0, 0); guard++; end
    drive(0, 0, 1, 1);
    n_tests++;
    if (bus.time_tik !== 1'b1 || bus.running !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL terminal_with_over: got %h want %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 30; i++) begin
      drive(0, 0, (i == 10), 0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL over_pause_model cyc %0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_sync_and_async();
    int guard;
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    guard = 0;
    while (!bus.time_tik && guard < 3 * TPS) begin drive(0, 0, 0, 0); guard++; end
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    n_tests++;
    if (obs_vec() !== 13'd0) begin
      n_fail++; $display("FAIL sync_mid_window: got %h want %h", obs_vec(), 13'd0);
    end
    drive(0, 1, 0, 0);
    for (int i = 0; i < 15; i++) drive(0, 0, 0, 0);
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL pre_async_model: got %h want %h", obs_vec(), exp_vec());
    end
    #2 reset = 1'b0;
    #1;
    model_clear();
    n_tests++;
    if (obs_vec() !== 13'd0) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", obs_vec(), 13'd0);
    end
    @(negedge clock_25);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0);
      n_tests++;
      if (obs_vec() !== 13'd0) begin
        n_fail++; $display("FAIL post_async_idle: got %h want %h", obs_vec(), 13'd0);
      end
    end
  endtask

  task automatic test_random();
    bit s, st, p, o;
    for (int i = 0; i < 3000; i++) begin
      s  = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 9) == 0);
      p  = ($urandom_range(0, 14) == 0);
      o  = ($urandom_range(0, 79) == 0);
      drive(s, st, p, o);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_model step %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_pause();
    test_stop();
    test_simultaneous();
    test_sync_and_async();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
